// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t TEN_MAX = 4'd5;
  localparam bcd_t ONE_MAX = 4'd9;

  function automatic int counterWidth(input int hz);
    return (hz <= 2) ? 1 : $clog2(hz);
  endfunction

  // Last prescaler count of the given quarter of a second (1..4).
  function automatic int divPoint(input int hz, input int quarters);
    return (hz / 4) * quarters - 1;
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_mod60.sv
// Two-digit BCD counter 00..59; wrap flags an increment taken at 59.
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output bcd_t ten,
  output bcd_t one,
  output logic wrap
);

  bcd_t r_ten;
  bcd_t r_one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ten <= '0;
      r_one <= '0;
    end else if (inc) begin
      if (r_one == ONE_MAX) begin
        r_one <= '0;
        r_ten <= (r_ten == TEN_MAX) ? bcd_t'(0) : r_ten + bcd_t'(1);
      end else begin
        r_one <= r_one + bcd_t'(1);
      end
    end
  end

  assign ten  = r_ten;
  assign one  = r_one;
  assign wrap = inc & (r_ten == TEN_MAX) & (r_one == ONE_MAX);

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss stopwatch core driven by clock-enable ticks from a single system clock.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic pause_pb,
  input  logic adjust,
  input  logic select,
  output bcd_t min_ten,
  output bcd_t min_one,
  output bcd_t sec_ten,
  output bcd_t sec_one,
  output logic blank_min,
  output logic blank_sec,
  output logic paused,
  output logic sec_pulse
);

  localparam int PC_W = counterWidth(CLK_HZ);
  localparam logic [PC_W-1:0] PC_Q1   = PC_W'(divPoint(CLK_HZ, 1));
  localparam logic [PC_W-1:0] PC_HALF = PC_W'(divPoint(CLK_HZ, 2));
  localparam logic [PC_W-1:0] PC_Q3   = PC_W'(divPoint(CLK_HZ, 3));
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(divPoint(CLK_HZ, 4));

  logic [PC_W-1:0] r_pc;
  logic            r_adjQ;
  logic            r_pauseQ;
  logic            r_paused;
  logic            r_blinkPh;
  logic            r_secPulse;

  logic w_adjChange;
  logic w_t1;
  logic w_t2;
  logic w_t4;
  logic w_pauseRise;
  logic w_secInc;
  logic w_minInc;
  logic w_secWrap;
  logic w_minWrap;

  // A mode change restarts the prescaler and suppresses every tick that cycle.
  always_comb begin
    w_adjChange = (r_adjQ != adjust);
    w_t1        = ~w_adjChange & (r_pc == PC_LAST);
    w_t2        = ~w_adjChange & ((r_pc == PC_HALF) | (r_pc == PC_LAST));
    w_t4        = ~w_adjChange & ((r_pc == PC_Q1) | (r_pc == PC_HALF) |
                                  (r_pc == PC_Q3) | (r_pc == PC_LAST));
    w_pauseRise = pause_pb & ~r_pauseQ;
  end

  // Advance uses the pre-toggle pause state; only run mode carries seconds into minutes.
  always_comb begin
    w_secInc = 1'b0;
    w_minInc = 1'b0;
    if (!r_paused) begin
      if (adjust) begin
        w_secInc = w_t2 & ~select;
        w_minInc = w_t2 & select;
      end else begin
        w_secInc = w_t1;
        w_minInc = w_secWrap;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= '0;
      r_adjQ     <= 1'b0;
      r_pauseQ   <= 1'b0;
      r_paused   <= 1'b0;
      r_blinkPh  <= 1'b0;
      r_secPulse <= 1'b0;
    end else begin
      r_adjQ     <= adjust;
      r_pauseQ   <= pause_pb;
      r_secPulse <= w_secInc | w_minInc;
      if (w_adjChange || r_pc == PC_LAST) r_pc <= '0;
      else                                r_pc <= r_pc + PC_W'(1);
      if (w_pauseRise) r_paused <= ~r_paused;
      if (!adjust)   r_blinkPh <= 1'b0;
      else if (w_t4) r_blinkPh <= ~r_blinkPh;
    end
  end

  bcd_mod60 u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (w_secInc),
    .ten   (sec_ten),
    .one   (sec_one),
    .wrap  (w_secWrap)
  );

  bcd_mod60 u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (w_minInc),
    .ten   (min_ten),
    .one   (min_one),
    .wrap  (w_minWrap)
  );

  assign blank_min = adjust & select & r_blinkPh;
  assign blank_sec = adjust & ~select & r_blinkPh;
  assign paused    = r_paused;
  assign sec_pulse = r_secPulse;

  // Minutes rolling over 59 -> 00 has no consumer; no overflow flag is produced.
  logic w_unusedMinWrap;
  assign w_unusedMinWrap = w_minWrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core with CLK_HZ = 8 (one tick per 8 clocks).
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pause_pb = 1'b0;
  logic       adjust = 1'b0;
  logic       select = 1'b0;
  logic [3:0] min_ten, min_one, sec_ten, sec_one;
  logic       blank_min, blank_sec, paused, sec_pulse;
  logic [15:0] digits;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  logic [15:0] expQ[$];
  logic [15:0] expD;

  stopwatch_core #(.CLK_HZ(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .pause_pb  (pause_pb),
    .adjust    (adjust),
    .select    (select),
    .min_ten   (min_ten),
    .min_one   (min_one),
    .sec_ten   (sec_ten),
    .sec_one   (sec_one),
    .blank_min (blank_min),
    .blank_sec (blank_sec),
    .paused    (paused),
    .sec_pulse (sec_pulse)
  );

  always #5 clk = ~clk;

  assign digits = {min_ten, min_one, sec_ten, sec_one};

  always @(negedge clk) if (sec_pulse) pulseCount <= pulseCount + 1;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    expQ.push_back(16'h0000);
    #3;
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD || paused !== 1'b0 || sec_pulse !== 1'b0 || blank_min !== 1'b0 || blank_sec !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: digits=%h paused=%b pulse=%b bm=%b bs=%b, expected %h and flags 0",
               digits, paused, sec_pulse, blank_min, blank_sec, expD);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_run;
    int startCount;
    startCount = pulseCount;
    expQ.push_back(16'h0000);
    expQ.push_back(16'h0001);
    expQ.push_back(16'h0100);
    cycles(7);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD || sec_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_before_first_tick: digits=%h pulse=%b, expected %h pulse 0", digits, sec_pulse, expD);
    end
    cycles(1);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD || sec_pulse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_first_tick: digits=%h pulse=%b, expected %h pulse 1", digits, sec_pulse, expD);
    end
    cycles(472);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL run_one_minute: digits=%h, expected %h", digits, expD);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pulseCount - startCount !== 60) begin
      errors++;
      $display("[TB] FAIL run_pulse_count: got %0d, expected 60", pulseCount - startCount);
    end
  endtask

  task automatic test_wrap;
    expQ.push_back(16'h5958);
    expQ.push_back(16'h5959);
    expQ.push_back(16'h0000);
    cycles(28304);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycles(8);
      expD = expQ.pop_front();
      checks++;
      if (digits !== expD) begin
        errors++;
        $display("[TB] FAIL wrap_step%0d: digits=%h, expected %h", i, digits, expD);
      end
    end
  endtask

  task automatic test_pause;
    cycles(40);
    expQ.push_back(16'h0005);
    expQ.push_back(16'h0005);
    expQ.push_back(16'h0005);
    expQ.push_back(16'h0006);
    expQ.push_back(16'h0007);
    expQ.push_back(16'h0007);
    expQ.push_back(16'h0008);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL pause_start: digits=%h, expected %h", digits, expD);
    end
    pause_pb = 1'b1;
    cycles(1);
    checks++;
    if (paused !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_enter: paused=%b, expected 1", paused);
    end
    cycles(2);
    pause_pb = 1'b0;
    cycles(45);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD || paused !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_hold: digits=%h paused=%b, expected %h paused 1", digits, paused, expD);
    end
    pause_pb = 1'b1;
    cycles(1);
    checks++;
    if (paused !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_leave: paused=%b, expected 0", paused);
    end
    cycles(2);
    pause_pb = 1'b0;
    cycles(4);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL resume_not_yet: digits=%h, expected %h", digits, expD);
    end
    cycles(1);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL resume_tick: digits=%h, expected %h", digits, expD);
    end
    cycles(7);
    pause_pb = 1'b1;
    cycles(1);
    pause_pb = 1'b0;
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD || paused !== 1'b1) begin
      errors++;
      $display("[TB] FAIL press_on_tick_run: digits=%h paused=%b, expected %h paused 1", digits, paused, expD);
    end
    cycles(7);
    pause_pb = 1'b1;
    cycles(1);
    pause_pb = 1'b0;
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD || paused !== 1'b0) begin
      errors++;
      $display("[TB] FAIL press_on_tick_paused: digits=%h paused=%b, expected %h paused 0", digits, paused, expD);
    end
    cycles(8);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL after_unpause: digits=%h, expected %h", digits, expD);
    end
  endtask

  task automatic test_adjust;
    logic expBlink;
    cycles(407);
    adjust = 1'b1;
    select = 1'b0;
    for (int k = 0; k <= 16; k++)
      expQ.push_back((k < 4) ? 16'h0058 : (k < 8) ? 16'h0059 : (k < 12) ? 16'h0000 :
                     (k < 16) ? 16'h0100 : 16'h0200);
    for (int k = 0; k <= 16; k++) begin
      cycles(1);
      if (k == 8) select = 1'b1;
      expD = expQ.pop_front();
      expBlink = ((k / 2) % 2) == 1;
      checks++;
      if (digits !== expD) begin
        errors++;
        $display("[TB] FAIL adjust_digits_k%0d: digits=%h, expected %h", k, digits, expD);
      end
      checks++;
      if (blank_min !== (select & expBlink) || blank_sec !== (~select & expBlink)) begin
        errors++;
        $display("[TB] FAIL adjust_blink_k%0d: bm=%b bs=%b, expected bm=%b bs=%b",
                 k, blank_min, blank_sec, select & expBlink, ~select & expBlink);
      end
    end
  endtask

  task automatic test_mode_switch;
    expQ.push_back(16'h0300);
    expQ.push_back(16'h0300);
    expQ.push_back(16'h0300);
    expQ.push_back(16'h0301);
    cycles(7);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL before_switch: digits=%h, expected %h", digits, expD);
    end
    adjust = 1'b0;
    cycles(1);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD || blank_min !== 1'b0 || sec_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL switch_no_tick: digits=%h bm=%b pulse=%b, expected %h bm 0 pulse 0",
               digits, blank_min, sec_pulse, expD);
    end
    cycles(7);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL switch_wait: digits=%h, expected %h", digits, expD);
    end
    cycles(1);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL switch_first_run_tick: digits=%h, expected %h", digits, expD);
    end
  endtask

  task automatic test_async_reset;
    adjust = 1'b1;
    select = 1'b1;
    expQ.push_back(16'h1201);
    expQ.push_back(16'h1234);
    expQ.push_back(16'h0000);
    expQ.push_back(16'h0000);
    expQ.push_back(16'h0001);
    cycles(37);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL set_minutes: digits=%h, expected %h", digits, expD);
    end
    select = 1'b0;
    cycles(132);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL set_seconds: digits=%h, expected %h", digits, expD);
    end
    #2;
    reset = 1'b0;
    #1;
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD || paused !== 1'b0 || sec_pulse !== 1'b0 || blank_min !== 1'b0 || blank_sec !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: digits=%h paused=%b pulse=%b bm=%b bs=%b, expected %h and flags 0",
               digits, paused, sec_pulse, blank_min, blank_sec, expD);
    end
    adjust = 1'b0;
    select = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycles(7);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL restart_wait: digits=%h, expected %h", digits, expD);
    end
    cycles(1);
    expD = expQ.pop_front();
    checks++;
    if (digits !== expD) begin
      errors++;
      $display("[TB] FAIL restart_tick: digits=%h, expected %h", digits, expD);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_pause();
    test_adjust();
    test_mode_switch();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Single-clock BCD mm:ss timekeeping core. It replaces derived-clock counting with clock-enable ticks generated from the system clock.
- Takes the debounced pause level plus the adjust and select switches, and produces four BCD digits and field-blank flags.
- Sits directly upstream of the seven-segment scan/decoder stage, which consumes the digits and blank flags.

Parameters:
- CLK_HZ, 100_000_000: system clock cycles per second. Must be a multiple of 4 and ≥4. The bench uses 8.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pause_pb  in  1  debounced pause button level, synchronous to clk.
- adjust  in  1  1 = adjust mode, 0 = run mode; synchronous level.
- select  in  1  field select in adjust mode: 1 = minutes, 0 = seconds.
- min_ten  out  4  BCD minutes tens digit, 0..5.
- min_one  out  4  BCD minutes ones digit, 0..9.
- sec_ten  out  4  BCD seconds tens digit, 0..5.
- sec_one  out  4  BCD seconds ones digit, 0..9.
- blank_min  out  1  blank the minute digits this cycle (adjust blink).
- blank_sec  out  1  blank the second digits this cycle (adjust blink).
- paused  out  1  current pause state.
- sec_pulse  out  1  one-cycle strobe, high in the cycle after any digit update.

Behaviour:
- Reset (reset=0, asynchronous):
  - All digits 0. paused=0. Blank flags 0. sec_pulse 0.
  - Prescaler 0, blink phase 0, pause-edge register 0.
  - Release is synchronous to clk; the first tick comes CLK_HZ (or CLK_HZ/2) cycles after release.
- Prescaler:
  - Counter pc runs 0..CLK_HZ-1 and wraps.
  - Enables are single-cycle and combinational from pc:
    - t1 when pc==CLK_HZ-1.
    - t2 when pc==CLK_HZ/2-1 or pc==CLK_HZ-1.
    - t4 when pc mod (CLK_HZ/4) == CLK_HZ/4-1.
  - Any change of adjust (registered adj_q != adjust) forces pc to 0 that cycle. No tick is produced in that cycle, so the first tick in the new mode is a full period away.
- Pause:
  - A rising edge of pause_pb (pause_pb=1, previous sample 0) toggles paused. A held button toggles only once.
  - Advance decisions use the pre-toggle paused value. A tick coinciding with the press therefore still advances when going run→pause, and does not advance when going pause→run.
- Run mode (adjust=0):
  - On t1 with paused=0, mm:ss increments by one.
  - sec_one 9→0 carries into sec_ten. sec_ten 5→0 carries into minutes.
  - 59:59 → 00:00 with no overflow flag.
- Adjust mode (adjust=1):
  - On t2 with paused=0, only the selected field increments modulo 60, with no carry between fields. Seconds 59→00 leaves minutes untouched; minutes 59→00 likewise.
  - The select value in the tick cycle decides which field advances.
- Blink:
  - blink_ph toggles on t4 while adjust=1 and is cleared while adjust=0.
  - blank_min = adjust & select & blink_ph.
  - blank_sec = adjust & ~select & blink_ph.
  - Blanking continues while paused.
- Timing:
  - Digits are registered and change one cycle after the enabling tick cycle; sec_pulse is high in that same cycle.
  - Digit outputs are never outside their BCD range.
  - Simultaneous adjust change and tick: the pc clear wins, so there is no advance.

Decomposition:
- Shared package stopwatch_pkg:
  - typedef bcd_t (4-bit).
  - Constants TEN_MAX=5 and ONE_MAX=9.
  - Helper function for CLK_HZ-derived divisor constants.
- One sub-module, bcd_mod60:
  - Inputs: clk, reset, inc. Outputs: ten, one (0..59), wrap.
  - wrap is combinational: high when inc is asserted at 59.
  - Instantiated twice. The seconds instance's wrap is gated into the minutes instance's inc in run mode only.

Test Plan (CLK_HZ=8):
- Reset then run, adjust=0, for 8*60 cycles → digits read 01:00 and sec_pulse has fired 60 times; the first increment lands 8 cycles after reset release.
- Preload to 59:58 by running, then two more t1 ticks → 59:59, then 00:00, with all digits 0 after the wrap.
- Pulse pause_pb for 3 cycles at count 00:05 → paused=1 and the count holds for ≥40 cycles; a second pulse gives paused=0 and counting resumes at 00:06 after 8 cycles. A press coincident with t1 still advances once.
- adjust=1, select=0 at 00:58 → 00:59 after 4 cycles, then 00:00 after 8 cycles, minutes unchanged. With select=1, minutes advance every 4 cycles and blank_min toggles every 2 cycles while blank_sec=0.
- Toggle adjust in the cycle pc==7 → no increment in that cycle, and the next increment comes 4 cycles (adjust) or 8 cycles (run) later.
- Assert reset=0 mid-count at 12:34, asynchronously between clock edges → all outputs 0 immediately, before the next clk edge; after release, counting restarts from 00:00.
